// File: rtl/pc_next_ctrl.sv
// Next-PC selection and pipeline keep/flush/bubble control: branch/jump redirect,
// load-use interlock, multi-cycle data-memory stall sequencing and a stall counter.
module pc_next_ctrl #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter int unsigned MEM_LAT   = 3,
   parameter int unsigned CNT_W     = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PC_cur,
   input  logic        ID_Jump,
   input  logic [31:0] ID_JumpTarget,
   input  logic        EX_BranchTaken,
   input  logic [31:0] EX_BranchTarget,
   input  logic        ID_EX_MemRead,
   input  logic [4:0]  ID_EX_Rt,
   input  logic [4:0]  IF_ID_Rs,
   input  logic [4:0]  IF_ID_Rt,
   input  logic        IF_ID_UsesRt,
   input  logic        MEM_Start,
   output logic [31:0] PC_i,
   output logic        PC_Keep,
   output logic        IF_ID_Keep,
   output logic        IF_ID_Flush,
   output logic        ID_EX_Keep,
   output logic        ID_EX_Flush,
   output logic        EX_MEM_Keep,
   output logic        MEM_WB_Bubble,
   output logic [31:0] Stall_Cnt
);

   typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_LAST} state_t;

   localparam bit             MULTI_CYC = (MEM_LAT >= 2);
   localparam bit             LONG_CYC  = (MEM_LAT >= 3);
   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'((MEM_LAT >= 2) ? (MEM_LAT - 2) : 0);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           st, st_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             mem_stall;
   logic             load_use;
   logic [31:0]      pc_seq;

   assign mem_stall = (st == RUN && MEM_Start && MULTI_CYC) || (st == MEM_WAIT);
   assign load_use  = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                      ((ID_EX_Rt == IF_ID_Rs) || (IF_ID_UsesRt && ID_EX_Rt == IF_ID_Rt));
   assign pc_seq    = PC_cur + 32'd4;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st  <= RUN;
         cnt <= '0;
      end else begin
         st  <= st_nxt;
         cnt <= cnt_nxt;
      end
   end

   always_comb begin
      st_nxt  = st;
      cnt_nxt = cnt;
      case (st)
         RUN: begin
            if (MEM_Start && LONG_CYC) begin
               cnt_nxt = WAIT_INIT;
               st_nxt  = MEM_WAIT;
            end else if (MEM_Start && MULTI_CYC) begin
               st_nxt  = MEM_LAST;
            end
         end
         MEM_WAIT: begin
            cnt_nxt = cnt - CNT_ONE;
            if (cnt == CNT_ONE) st_nxt = MEM_LAST;
         end
         MEM_LAST: st_nxt = RUN;
         default:  st_nxt = RUN;
      endcase
   end

   // Mem stall masks redirects; held stages re-present them once the access ends.
   always_comb begin
      PC_i          = pc_seq;
      PC_Keep       = 1'b0;
      IF_ID_Keep    = 1'b0;
      IF_ID_Flush   = 1'b0;
      ID_EX_Keep    = 1'b0;
      ID_EX_Flush   = 1'b0;
      EX_MEM_Keep   = 1'b0;
      MEM_WB_Bubble = 1'b0;
      if (!reset) begin
         PC_i = RESET_VEC;
      end else if (mem_stall) begin
         PC_Keep       = 1'b1;
         IF_ID_Keep    = 1'b1;
         ID_EX_Keep    = 1'b1;
         EX_MEM_Keep   = 1'b1;
         MEM_WB_Bubble = 1'b1;
      end else if (EX_BranchTaken) begin
         PC_i        = EX_BranchTarget;
         IF_ID_Flush = 1'b1;
         ID_EX_Flush = 1'b1;
      end else if (load_use) begin
         PC_Keep     = 1'b1;
         IF_ID_Keep  = 1'b1;
         ID_EX_Flush = 1'b1;
      end else if (ID_Jump) begin
         PC_i        = ID_JumpTarget;
         IF_ID_Flush = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         Stall_Cnt <= '0;
      end else if (PC_Keep && (Stall_Cnt != '1)) begin
         Stall_Cnt <= Stall_Cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_pc_next_ctrl.sv
// Directed self-checking bench for pc_next_ctrl with MEM_LAT=3 and a non-zero reset vector.
module tb_pc_next_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PC_cur;
   logic        ID_Jump;
   logic [31:0] ID_JumpTarget;
   logic        EX_BranchTaken;
   logic [31:0] EX_BranchTarget;
   logic        ID_EX_MemRead;
   logic [4:0]  ID_EX_Rt;
   logic [4:0]  IF_ID_Rs;
   logic [4:0]  IF_ID_Rt;
   logic        IF_ID_UsesRt;
   logic        MEM_Start;
   logic [31:0] PC_i;
   logic        PC_Keep, IF_ID_Keep, IF_ID_Flush, ID_EX_Keep, ID_EX_Flush;
   logic        EX_MEM_Keep, MEM_WB_Bubble;
   logic [31:0] Stall_Cnt;
   logic [6:0]  ctrl;

   int checks = 0;
   int errors = 0;

   // {PC_Keep, IF_ID_Keep, IF_ID_Flush, ID_EX_Keep, ID_EX_Flush, EX_MEM_Keep, MEM_WB_Bubble}
   localparam logic [6:0] C_NONE   = 7'b0000000;
   localparam logic [6:0] C_BRANCH = 7'b0010100;
   localparam logic [6:0] C_JUMP   = 7'b0010000;
   localparam logic [6:0] C_LDUSE  = 7'b1100100;
   localparam logic [6:0] C_MEM    = 7'b1101011;

   assign ctrl = {PC_Keep, IF_ID_Keep, IF_ID_Flush, ID_EX_Keep, ID_EX_Flush,
                  EX_MEM_Keep, MEM_WB_Bubble};

   always #5 clk = ~clk;

   pc_next_ctrl #(
      .RESET_VEC(32'h0000_0100),
      .MEM_LAT(3),
      .CNT_W(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .PC_cur(PC_cur),
      .ID_Jump(ID_Jump),
      .ID_JumpTarget(ID_JumpTarget),
      .EX_BranchTaken(EX_BranchTaken),
      .EX_BranchTarget(EX_BranchTarget),
      .ID_EX_MemRead(ID_EX_MemRead),
      .ID_EX_Rt(ID_EX_Rt),
      .IF_ID_Rs(IF_ID_Rs),
      .IF_ID_Rt(IF_ID_Rt),
      .IF_ID_UsesRt(IF_ID_UsesRt),
      .MEM_Start(MEM_Start),
      .PC_i(PC_i),
      .PC_Keep(PC_Keep),
      .IF_ID_Keep(IF_ID_Keep),
      .IF_ID_Flush(IF_ID_Flush),
      .ID_EX_Keep(ID_EX_Keep),
      .ID_EX_Flush(ID_EX_Flush),
      .EX_MEM_Keep(EX_MEM_Keep),
      .MEM_WB_Bubble(MEM_WB_Bubble),
      .Stall_Cnt(Stall_Cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      ID_Jump         = 1'b0;
      ID_JumpTarget   = 32'h0000_0080;
      EX_BranchTaken  = 1'b0;
      EX_BranchTarget = 32'h0000_0040;
      ID_EX_MemRead   = 1'b0;
      ID_EX_Rt        = 5'd0;
      IF_ID_Rs        = 5'd0;
      IF_ID_Rt        = 5'd0;
      IF_ID_UsesRt    = 1'b0;
      MEM_Start       = 1'b0;
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      reset  = 1'b0;
      PC_cur = 32'h0000_0010;
      idle();
      ID_Jump = 1'b1;
      #3;
      chk("rst_pc", PC_i, 32'h0000_0100);
      chk("rst_ctrl", {25'd0, ctrl}, {25'd0, C_NONE});
      chk("rst_cnt", Stall_Cnt, 32'd0);

      step(); reset = 1'b1; idle();
      #1;
      chk("seq_pc", PC_i, 32'h0000_0014);
      chk("seq_ctrl", {25'd0, ctrl}, {25'd0, C_NONE});

      step(); PC_cur = 32'hFFFF_FFFC;
      #1;
      chk("wrap_pc", PC_i, 32'h0000_0000);

      step(); PC_cur = 32'h0000_0020; EX_BranchTaken = 1'b1; ID_Jump = 1'b1;
      #1;
      chk("brj_pc", PC_i, 32'h0000_0040);
      chk("brj_ctrl", {25'd0, ctrl}, {25'd0, C_BRANCH});

      step(); EX_BranchTaken = 1'b0;
      #1;
      chk("jmp_pc", PC_i, 32'h0000_0080);
      chk("jmp_ctrl", {25'd0, ctrl}, {25'd0, C_JUMP});

      // load-use on rs, with a jump also pending in ID
      step(); idle(); ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd5; IF_ID_Rs = 5'd5; ID_Jump = 1'b1;
      #1;
      chk("ldu_pc", PC_i, 32'h0000_0024);
      chk("ldu_ctrl", {25'd0, ctrl}, {25'd0, C_LDUSE});

      step(); idle();
      #1;
      chk("ldu_cnt", Stall_Cnt, 32'd1);
      chk("ldu_release", {25'd0, ctrl}, {25'd0, C_NONE});

      step(); ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd0; IF_ID_Rs = 5'd0;
      #1;
      chk("ldu_r0", {25'd0, ctrl}, {25'd0, C_NONE});

      step(); ID_EX_Rt = 5'd5; IF_ID_Rs = 5'd3; IF_ID_Rt = 5'd5; IF_ID_UsesRt = 1'b0;
      #1;
      chk("ldu_nort", {25'd0, ctrl}, {25'd0, C_NONE});

      step(); IF_ID_UsesRt = 1'b1;
      #1;
      chk("ldu_rt", {25'd0, ctrl}, {25'd0, C_LDUSE});

      // plain MEM_LAT=3 access, MEM_Start held three cycles
      step(); idle(); PC_cur = 32'h0000_0200; MEM_Start = 1'b1;
      #1;
      chk("mem0_cnt", Stall_Cnt, 32'd2);
      chk("mem0_ctrl", {25'd0, ctrl}, {25'd0, C_MEM});
      chk("mem0_pc", PC_i, 32'h0000_0204);
      step();
      #1;
      chk("mem1_ctrl", {25'd0, ctrl}, {25'd0, C_MEM});
      step();
      #1;
      chk("mem2_ctrl", {25'd0, ctrl}, {25'd0, C_NONE});
      chk("mem2_pc", PC_i, 32'h0000_0204);
      chk("mem2_cnt", Stall_Cnt, 32'd4);
      step(); MEM_Start = 1'b0;
      #1;
      chk("mem3_ctrl", {25'd0, ctrl}, {25'd0, C_NONE});

      // access with a taken branch held in EX throughout
      step(); MEM_Start = 1'b1; EX_BranchTaken = 1'b1;
      #1;
      chk("mbr0_ctrl", {25'd0, ctrl}, {25'd0, C_MEM});
      step();
      #1;
      chk("mbr1_ctrl", {25'd0, ctrl}, {25'd0, C_MEM});
      step();
      #1;
      chk("mbr2_ctrl", {25'd0, ctrl}, {25'd0, C_BRANCH});
      chk("mbr2_pc", PC_i, 32'h0000_0040);
      chk("mbr2_cnt", Stall_Cnt, 32'd6);

      // asynchronous reset while in MEM_WAIT
      step(); idle(); MEM_Start = 1'b1;
      #1;
      chk("ar0_ctrl", {25'd0, ctrl}, {25'd0, C_MEM});
      step(); MEM_Start = 1'b0;
      #1;
      chk("ar1_ctrl", {25'd0, ctrl}, {25'd0, C_MEM});
      chk("ar1_cnt", Stall_Cnt, 32'd7);
      #1 reset = 1'b0;
      #1;
      chk("ar_pc", PC_i, 32'h0000_0100);
      chk("ar_ctrl", {25'd0, ctrl}, {25'd0, C_NONE});
      chk("ar_cnt", Stall_Cnt, 32'd0);

      step(); reset = 1'b1;
      #1;
      chk("post_ctrl", {25'd0, ctrl}, {25'd0, C_NONE});
      chk("post_pc", PC_i, 32'h0000_0204);
      step(); MEM_Start = 1'b1;
      #1;
      chk("post0_ctrl", {25'd0, ctrl}, {25'd0, C_MEM});
      step(); MEM_Start = 1'b0;
      #1;
      chk("post1_ctrl", {25'd0, ctrl}, {25'd0, C_MEM});
      step();
      #1;
      chk("post2_ctrl", {25'd0, ctrl}, {25'd0, C_NONE});
      chk("post2_cnt", Stall_Cnt, 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
